accel_buffer_sched: RTL and testbench



---
 rtl/accel_buffer_sched_if.sv | 41 ++++
 rtl/accel_buffer_sched.sv | 253 +++++++++++++++++++++++++
 tb/tb_accel_buffer_sched.sv | 264 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/accel_buffer_sched_if.sv
// -----------------------------------------------------------------------------
// accel_buffer_sched_if
// Purpose : Bundles the job-descriptor handshake and the shared memory command
//           port of the accelerator buffer scheduler.
// Signals :
//   job_valid/job_ready         job descriptor handshake
//   job_src/job_dst/job_len     descriptor fields (word addresses, word count)
//   mem_cmd_valid/mem_cmd_ready memory command handshake
//   mem_cmd_wr                  1 = write burst (to memory), 0 = read burst
//   mem_cmd_addr/mem_cmd_len    burst start word address and length
//   mem_burst_done              one-cycle pulse, issued burst fully moved
// Modports:
//   master : the scheduler (masters the memory command port)
//   slave  : the environment (job source and memory controller)
// -----------------------------------------------------------------------------
interface accel_buffer_sched_if #(
   parameter int ADDR_W = 32,
   parameter int LEN_W  = 16
);
   logic              job_valid;
   logic              job_ready;
   logic [ADDR_W-1:0] job_src;
   logic [ADDR_W-1:0] job_dst;
   logic [LEN_W-1:0]  job_len;
   logic              mem_cmd_valid;
   logic              mem_cmd_ready;
   logic              mem_cmd_wr;
   logic [ADDR_W-1:0] mem_cmd_addr;
   logic [LEN_W-1:0]  mem_cmd_len;
   logic              mem_burst_done;

   modport master (
      input  job_valid, job_src, job_dst, job_len, mem_cmd_ready, mem_burst_done,
      output job_ready, mem_cmd_valid, mem_cmd_wr, mem_cmd_addr, mem_cmd_len
   );

   modport slave (
      output job_valid, job_src, job_dst, job_len, mem_cmd_ready, mem_burst_done,
      input  job_ready, mem_cmd_valid, mem_cmd_wr, mem_cmd_addr, mem_cmd_len
   );
endinterface

// File: rtl/accel_buffer_sched.sv
// -----------------------------------------------------------------------------
// accel_buffer_sched
// Purpose : Job-level scheduler for the accelerator buffer pair. Takes one job
//           descriptor and issues read bursts (fill input FIFO) and write
//           bursts (drain output FIFO) on a single memory command port with
//           round-robin arbitration, gated by the FIFO programmable flags.
// Ports   :
//   mem_clk            scheduler clock (memory domain)
//   rst                synchronous active-high reset
//   bus                accel_buffer_sched_if.master (job + memory command)
//   input_buff_full    input FIFO programmable-full flag
//   output_buff_empty  output FIFO programmable-empty flag
//   accel_done         level, accelerator has produced all output
//   busy               job in progress
//   done               one-cycle pulse at job completion
//   stat_rd_stall/stat_wr_stall  stall counters (only with the macro below)
// Build option:
//   ACCEL_BUFFER_SCHED_STATS_EN  adds saturating 32-bit stall counters.
// All outputs are registered; their next values are derived from the next
// state so they line up with the state register.
// -----------------------------------------------------------------------------
module accel_buffer_sched #(
   parameter int ADDR_W    = 32,
   parameter int LEN_W     = 16,
   parameter int BURST_LEN = 4
) (
   input  logic                        mem_clk,
   input  logic                        rst,
   accel_buffer_sched_if.master        bus,
   input  logic                        input_buff_full,
   input  logic                        output_buff_empty,
   input  logic                        accel_done,
   output logic                        busy,
   output logic                        done
`ifdef ACCEL_BUFFER_SCHED_STATS_EN
   ,
   output logic [31:0]                 stat_rd_stall,
   output logic [31:0]                 stat_wr_stall
`endif
);

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_SCHED = 3'd1,
      ST_ISSUE = 3'd2,
      ST_WAIT  = 3'd3,
      ST_DONE  = 3'd4
   } state_t;

   localparam logic [LEN_W-1:0] BURST_L = LEN_W'(BURST_LEN);

   // Burst length for a given remaining count: min(BURST_LEN, rem).
   function automatic logic [LEN_W-1:0] burst_len_f(input logic [LEN_W-1:0] rem);
      if (rem > BURST_L) begin
         return BURST_L;
      end else begin
         return rem;
      end
   endfunction

   state_t            state_q, state_d;
   logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
   logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
   logic [LEN_W-1:0]  rd_rem_q, rd_rem_d;
   logic [LEN_W-1:0]  wr_rem_q, wr_rem_d;
   logic              cmd_wr_q, cmd_wr_d;
   logic [ADDR_W-1:0] cmd_addr_q, cmd_addr_d;
   logic [LEN_W-1:0]  cmd_len_q, cmd_len_d;
   logic              cmd_valid_q, cmd_valid_d;
   // 1 = last granted burst was a write; reset value makes reads win first.
   logic              last_wr_q, last_wr_d;
   logic              job_ready_q, job_ready_d;
   logic              busy_q, busy_d;
   logic              done_q, done_d;
`ifdef ACCEL_BUFFER_SCHED_STATS_EN
   logic [31:0]       stat_rd_q, stat_rd_d;
   logic [31:0]       stat_wr_q, stat_wr_d;
`endif

   logic rd_ok_s;
   logic wr_ok_s;
   logic grant_rd_s;
   logic grant_wr_s;

   // Eligibility and round-robin grant, only consumed in SCHED.
   always_comb begin
      rd_ok_s    = (rd_rem_q != '0) && !input_buff_full;
      // accel_done lets the tail drain while the programmable-empty flag is still set
      wr_ok_s    = (wr_rem_q != '0) && (!output_buff_empty || accel_done);
      grant_rd_s = rd_ok_s && (!wr_ok_s || last_wr_q);
      grant_wr_s = wr_ok_s && (!rd_ok_s || !last_wr_q);
   end

   // Next-state, datapath updates and next registered outputs.
   always_comb begin
      state_d   = state_q;
      rd_addr_d = rd_addr_q;
      wr_addr_d = wr_addr_q;
      rd_rem_d  = rd_rem_q;
      wr_rem_d  = wr_rem_q;
      cmd_wr_d  = cmd_wr_q;
      cmd_addr_d = cmd_addr_q;
      cmd_len_d = cmd_len_q;
      last_wr_d = last_wr_q;
`ifdef ACCEL_BUFFER_SCHED_STATS_EN
      stat_rd_d = stat_rd_q;
      stat_wr_d = stat_wr_q;
`endif

      case (state_q)
         ST_IDLE: begin
            if (bus.job_valid && job_ready_q) begin
               rd_addr_d = bus.job_src;
               wr_addr_d = bus.job_dst;
               rd_rem_d  = bus.job_len;
               wr_rem_d  = bus.job_len;
`ifdef ACCEL_BUFFER_SCHED_STATS_EN
               stat_rd_d = 32'd0;
               stat_wr_d = 32'd0;
`endif
               if (bus.job_len == '0) begin
                  state_d = ST_DONE;
               end else begin
                  state_d = ST_SCHED;
               end
            end else begin
               state_d = ST_IDLE;
            end
         end

         ST_SCHED: begin
`ifdef ACCEL_BUFFER_SCHED_STATS_EN
            if ((rd_rem_q != '0) && input_buff_full && (stat_rd_q != 32'hFFFF_FFFF)) begin
               stat_rd_d = stat_rd_q + 32'd1;
            end else begin
               stat_rd_d = stat_rd_q;
            end
            if ((wr_rem_q != '0) && !wr_ok_s && (stat_wr_q != 32'hFFFF_FFFF)) begin
               stat_wr_d = stat_wr_q + 32'd1;
            end else begin
               stat_wr_d = stat_wr_q;
            end
`endif
            if ((rd_rem_q == '0) && (wr_rem_q == '0)) begin
               state_d = ST_DONE;
            end else if (grant_rd_s) begin
               state_d    = ST_ISSUE;
               cmd_wr_d   = 1'b0;
               cmd_addr_d = rd_addr_q;
               cmd_len_d  = burst_len_f(rd_rem_q);
            end else if (grant_wr_s) begin
               state_d    = ST_ISSUE;
               cmd_wr_d   = 1'b1;
               cmd_addr_d = wr_addr_q;
               cmd_len_d  = burst_len_f(wr_rem_q);
            end else begin
               state_d = ST_SCHED;
            end
         end

         ST_ISSUE: begin
            if (bus.mem_cmd_ready) begin
               state_d   = ST_WAIT;
               last_wr_d = cmd_wr_q;
            end else begin
               state_d = ST_ISSUE;
            end
         end

         ST_WAIT: begin
            if (bus.mem_burst_done) begin
               state_d = ST_SCHED;
               if (cmd_wr_q) begin
                  wr_rem_d  = wr_rem_q - cmd_len_q;
                  wr_addr_d = wr_addr_q + ADDR_W'(cmd_len_q);
               end else begin
                  rd_rem_d  = rd_rem_q - cmd_len_q;
                  rd_addr_d = rd_addr_q + ADDR_W'(cmd_len_q);
               end
            end else begin
               state_d = ST_WAIT;
            end
         end

         ST_DONE: begin
            state_d = ST_IDLE;
         end

         default: begin
            state_d = ST_IDLE;
         end
      endcase

      job_ready_d = (state_d == ST_IDLE);
      busy_d      = (state_d != ST_IDLE);
      done_d      = (state_d == ST_DONE);
      cmd_valid_d = (state_d == ST_ISSUE);
   end

   // State, datapath and output registers with synchronous reset.
   always_ff @(posedge mem_clk) begin
      if (rst) begin
         state_q     <= ST_IDLE;
         rd_addr_q   <= '0;
         wr_addr_q   <= '0;
         rd_rem_q    <= '0;
         wr_rem_q    <= '0;
         cmd_wr_q    <= 1'b0;
         cmd_addr_q  <= '0;
         cmd_len_q   <= '0;
         cmd_valid_q <= 1'b0;
         last_wr_q   <= 1'b1;
         job_ready_q <= 1'b1;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
`ifdef ACCEL_BUFFER_SCHED_STATS_EN
         stat_rd_q   <= 32'd0;
         stat_wr_q   <= 32'd0;
`endif
      end else begin
         state_q     <= state_d;
         rd_addr_q   <= rd_addr_d;
         wr_addr_q   <= wr_addr_d;
         rd_rem_q    <= rd_rem_d;
         wr_rem_q    <= wr_rem_d;
         cmd_wr_q    <= cmd_wr_d;
         cmd_addr_q  <= cmd_addr_d;
         cmd_len_q   <= cmd_len_d;
         cmd_valid_q <= cmd_valid_d;
         last_wr_q   <= last_wr_d;
         job_ready_q <= job_ready_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
`ifdef ACCEL_BUFFER_SCHED_STATS_EN
         stat_rd_q   <= stat_rd_d;
         stat_wr_q   <= stat_wr_d;
`endif
      end
   end

   assign bus.job_ready     = job_ready_q;
   assign bus.mem_cmd_valid = cmd_valid_q;
   assign bus.mem_cmd_wr    = cmd_wr_q;
   assign bus.mem_cmd_addr  = cmd_addr_q;
   assign bus.mem_cmd_len   = cmd_len_q;
   assign busy              = busy_q;
   assign done              = done_q;
`ifdef ACCEL_BUFFER_SCHED_STATS_EN
   assign stat_rd_stall     = stat_rd_q;
   assign stat_wr_stall     = stat_wr_q;
`endif

endmodule

// File: tb/tb_accel_buffer_sched.sv
// -----------------------------------------------------------------------------
// tb_accel_buffer_sched
// Directed self-checking bench for accel_buffer_sched. Inputs are driven and
// outputs sampled 1 time unit after each rising edge of mem_clk.
// -----------------------------------------------------------------------------
module tb_accel_buffer_sched;

   localparam int ADDR_W = 32;
   localparam int LEN_W  = 16;

   logic mem_clk = 1'b0;
   logic rst;
   logic input_buff_full;
   logic output_buff_empty;
   logic accel_done;
   logic busy;
   logic done;
`ifdef ACCEL_BUFFER_SCHED_STATS_EN
   logic [31:0] stat_rd_stall;
   logic [31:0] stat_wr_stall;
`endif

   accel_buffer_sched_if #(.ADDR_W(ADDR_W), .LEN_W(LEN_W)) bus ();

   accel_buffer_sched #(.ADDR_W(ADDR_W), .LEN_W(LEN_W), .BURST_LEN(4)) dut (
      .mem_clk           (mem_clk),
      .rst               (rst),
      .bus               (bus),
      .input_buff_full   (input_buff_full),
      .output_buff_empty (output_buff_empty),
      .accel_done        (accel_done),
      .busy              (busy),
      .done              (done)
`ifdef ACCEL_BUFFER_SCHED_STATS_EN
      ,
      .stat_rd_stall     (stat_rd_stall),
      .stat_wr_stall     (stat_wr_stall)
`endif
   );

   always #5 mem_clk = ~mem_clk;

   int n_tests = 0;
   int n_fail  = 0;

   // Command log filled by run_auto.
   int          n_cmds;
   logic        log_wr   [16];
   logic [31:0] log_addr [16];
   logic [15:0] log_len  [16];
   int          bd_cnt = 0;
   logic        done_seen;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge mem_clk);
      #1;
   endtask

   task automatic start_job(input logic [31:0] src, input logic [31:0] dst, input logic [15:0] len);
      bus.job_src   = src;
      bus.job_dst   = dst;
      bus.job_len   = len;
      bus.job_valid = 1'b1;
      step();
      bus.job_valid = 1'b0;
   endtask

   // Acts as memory controller: accepts every command and returns
   // mem_burst_done so that it is sampled on the 3rd edge after the accept.
   task automatic run_auto(input int budget);
      logic hs;
      n_cmds    = 0;
      done_seen = 1'b0;
      bus.mem_cmd_ready = 1'b1;
      for (int c = 0; c < budget && !done_seen; c++) begin
         hs = bus.mem_cmd_valid && bus.mem_cmd_ready;
         if (hs && n_cmds < 16) begin
            log_wr[n_cmds]   = bus.mem_cmd_wr;
            log_addr[n_cmds] = bus.mem_cmd_addr;
            log_len[n_cmds]  = bus.mem_cmd_len;
            n_cmds++;
         end
         step();
         if (bd_cnt > 0) begin
            bd_cnt--;
            bus.mem_burst_done = (bd_cnt == 0);
         end else begin
            bus.mem_burst_done = 1'b0;
         end
         if (hs) bd_cnt = 2;
         if (done) done_seen = 1'b1;
      end
      bus.mem_cmd_ready  = 1'b0;
      bus.mem_burst_done = 1'b0;
      bd_cnt = 0;
      check("run_done_seen", {63'd0, done_seen}, 64'd1);
   endtask

   task automatic check_cmd(input int idx, input logic wr, input logic [31:0] addr, input logic [15:0] len);
      check($sformatf("cmd%0d_wr", idx),   {63'd0, log_wr[idx]},   {63'd0, wr});
      check($sformatf("cmd%0d_addr", idx), {32'd0, log_addr[idx]}, {32'd0, addr});
      check($sformatf("cmd%0d_len", idx),  {48'd0, log_len[idx]},  {48'd0, len});
   endtask

   initial begin
      rst               = 1'b1;
      input_buff_full   = 1'b0;
      output_buff_empty = 1'b0;
      accel_done        = 1'b0;
      bus.job_valid     = 1'b0;
      bus.job_src       = 32'd0;
      bus.job_dst       = 32'd0;
      bus.job_len       = 16'd0;
      bus.mem_cmd_ready = 1'b0;
      bus.mem_burst_done = 1'b0;
      step();
      step();

      // Reset state.
      check("rst_job_ready", {63'd0, bus.job_ready},     64'd1);
      check("rst_busy",      {63'd0, busy},              64'd0);
      check("rst_done",      {63'd0, done},              64'd0);
      check("rst_valid",     {63'd0, bus.mem_cmd_valid}, 64'd0);
      check("rst_wr",        {63'd0, bus.mem_cmd_wr},    64'd0);
      check("rst_addr",      {32'd0, bus.mem_cmd_addr},  64'd0);
      check("rst_len",       {48'd0, bus.mem_cmd_len},   64'd0);
      rst = 1'b0;
      step();

      // Zero-length job: straight to DONE, no command.
      start_job(32'h100, 32'h800, 16'd0);
      check("z_done_pulse", {63'd0, done},              64'd1);
      check("z_busy",       {63'd0, busy},              64'd1);
      check("z_ready_low",  {63'd0, bus.job_ready},     64'd0);
      check("z_no_valid",   {63'd0, bus.mem_cmd_valid}, 64'd0);
      step();
      check("z_done_clear", {63'd0, done},              64'd0);
      check("z_ready_back", {63'd0, bus.job_ready},     64'd1);
      check("z_busy_clear", {63'd0, busy},              64'd0);
      check("z_no_valid2",  {63'd0, bus.mem_cmd_valid}, 64'd0);

      // 10-word job, alternating read/write bursts.
      accel_done = 1'b1;
      start_job(32'h100, 32'h800, 16'd10);
      run_auto(200);
      check("alt_n_cmds", n_cmds, 6);
      check_cmd(0, 1'b0, 32'h100, 16'd4);
      check_cmd(1, 1'b1, 32'h800, 16'd4);
      check_cmd(2, 1'b0, 32'h104, 16'd4);
      check_cmd(3, 1'b1, 32'h804, 16'd4);
      check_cmd(4, 1'b0, 32'h108, 16'd2);
      check_cmd(5, 1'b1, 32'h808, 16'd2);
      step();
      check("alt_idle_ready", {63'd0, bus.job_ready}, 64'd1);
      check("alt_idle_busy",  {63'd0, busy},          64'd0);

      // Both sides blocked by flags: nothing issued.
      input_buff_full   = 1'b1;
      output_buff_empty = 1'b1;
      accel_done        = 1'b0;
      start_job(32'h100, 32'h200, 16'd4);
      begin
         int vcount = 0;
         for (int i = 0; i < 20; i++) begin
            if (bus.mem_cmd_valid) vcount++;
            step();
         end
         check("blk_no_cmd", vcount, 0);
      end
      input_buff_full = 1'b0;
      step();
      check("rel_valid", {63'd0, bus.mem_cmd_valid}, 64'd1);
      check("rel_wr",    {63'd0, bus.mem_cmd_wr},    64'd0);
      check("rel_addr",  {32'd0, bus.mem_cmd_addr},  64'h100);
      check("rel_len",   {48'd0, bus.mem_cmd_len},   64'd4);

      // Back-pressure: fields held while mem_cmd_ready is low.
      input_buff_full = 1'b1;  // flag change after grant must not cancel
      for (int i = 0; i < 5; i++) begin
         step();
         check($sformatf("hold%0d_valid", i), {63'd0, bus.mem_cmd_valid}, 64'd1);
         check($sformatf("hold%0d_wr", i),    {63'd0, bus.mem_cmd_wr},    64'd0);
         check($sformatf("hold%0d_addr", i),  {32'd0, bus.mem_cmd_addr},  64'h100);
         check($sformatf("hold%0d_len", i),   {48'd0, bus.mem_cmd_len},   64'd4);
      end
      bus.mem_cmd_ready = 1'b1;
      step();
      bus.mem_cmd_ready = 1'b0;
      check("acc_valid_drop", {63'd0, bus.mem_cmd_valid}, 64'd1 - 64'd1);
      begin
         int vcount = 0;
         for (int i = 0; i < 4; i++) begin
            step();
            if (bus.mem_cmd_valid) vcount++;
         end
         check("single_accept", vcount, 0);
      end
      // Complete the read, then the write tail drains via accel_done.
      bus.mem_burst_done = 1'b1;
      step();
      bus.mem_burst_done = 1'b0;
      input_buff_full = 1'b0;
      accel_done      = 1'b1;
      run_auto(100);
      check("tail_n_cmds", n_cmds, 1);
      check_cmd(0, 1'b1, 32'h200, 16'd4);
      step();

      // Reset while waiting for a burst.
      output_buff_empty = 1'b0;
      start_job(32'h300, 32'h400, 16'd8);
      bus.mem_cmd_ready = 1'b1;
      step();  // SCHED -> ISSUE
      step();  // handshake -> WAIT
      bus.mem_cmd_ready = 1'b0;
      check("pre_rst_busy", {63'd0, busy}, 64'd1);
      rst = 1'b1;
      step();
      rst = 1'b0;
      check("mr_job_ready", {63'd0, bus.job_ready},     64'd1);
      check("mr_busy",      {63'd0, busy},              64'd0);
      check("mr_valid",     {63'd0, bus.mem_cmd_valid}, 64'd0);
      check("mr_done",      {63'd0, done},              64'd0);
      bus.mem_burst_done = 1'b1;  // stray completion in IDLE is ignored
      step();
      bus.mem_burst_done = 1'b0;
      check("mr_stray_idle", {63'd0, bus.job_ready}, 64'd1);
      start_job(32'h500, 32'h600, 16'd4);
      run_auto(100);
      check("mr_n_cmds", n_cmds, 2);
      check_cmd(0, 1'b0, 32'h500, 16'd4);
      check_cmd(1, 1'b1, 32'h600, 16'd4);
      step();

      // job_valid held high with other fields while busy: ignored.
      start_job(32'h700, 32'h900, 16'd4);
      bus.job_src   = 32'hAAA;
      bus.job_dst   = 32'hBBB;
      bus.job_len   = 16'd8;
      bus.job_valid = 1'b1;
      run_auto(100);
      bus.job_valid = 1'b0;
      check("busy_n_cmds", n_cmds, 2);
      check_cmd(0, 1'b0, 32'h700, 16'd4);
      check_cmd(1, 1'b1, 32'h900, 16'd4);
      step();
      check("busy_end_ready", {63'd0, bus.job_ready}, 64'd1);
      check("busy_end_busy",  {63'd0, busy},          64'd0);
      step();
      check("busy_no_new_job", {63'd0, busy}, 64'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
